uart_tx_arbiter: RTL and testbench

//   Shares the single UART byte transmitter between NUM_REQ byte producers (debug dump, status

---
 rtl/uart_pkg.sv | 16 +
 rtl/rr_priority_picker.sv | 28 ++
 rtl/uart_tx_arbiter.sv | 92 +++++++++
 tb/tb_uart_tx_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit-side arbitration logic.
package uart_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic {
      ARB  = 1'b0,
      HOLD = 1'b1
   } arb_state_t;

   // Index width for a vector of n requesters; never narrower than one bit.
   function automatic int uart_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: the first set request strictly after rr_ptr wins,
// wrapping modulo NUM_REQ.
module rr_priority_picker
   import uart_pkg::*;
#(
   parameter int  NUM_REQ = 4,
   localparam int IDX_W   = uart_idx_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic               any_valid,
   output logic [IDX_W-1:0]   winner
);

   // Walk offsets from farthest to nearest so the nearest set request is written last.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      any_valid = 1'b0;
      winner    = '0;
      for (int off = NUM_REQ; off >= 1; off--) begin
         if (req[(int'(rr_ptr) + off) % NUM_REQ]) begin
            any_valid = 1'b1;
            winner    = IDX_W'((int'(rr_ptr) + off) % NUM_REQ);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with packet lock that shares one UART byte transmitter between
// NUM_REQ producers through a one-byte output buffer.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int  NUM_REQ   = 4,
   parameter int  MAX_BURST = 16,
   localparam int IDX_W     = uart_idx_w(NUM_REQ)
) (
   input  logic                      uart_samplig_clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_last,
   input  logic [BYTE_W*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      tx_valid,
   input  logic                      tx_ready,
   output logic [BYTE_W-1:0]         tx_data,
   output logic [IDX_W-1:0]          grant_id,
   output logic                      busy
);

   arb_state_t       state;
   arb_state_t       next_state;
   logic [IDX_W-1:0] rr_ptr;
   logic [7:0]       burst_cnt;
   logic             any_valid;
   logic [IDX_W-1:0] winner;
   logic             slot_free;
   logic             accept;
   logic             pkt_end;

   rr_priority_picker #(
      .NUM_REQ (NUM_REQ)
   ) u_picker (
      .req       (req_valid),
      .rr_ptr    (rr_ptr),
      .any_valid (any_valid),
      .winner    (winner)
   );

   // The buffer can take a byte when empty or when it is being drained this same edge.
   assign slot_free = !tx_valid || tx_ready;
   assign accept    = (state == HOLD) && slot_free && req_valid[grant_id];
   assign pkt_end   = accept && (req_last[grant_id] || (burst_cnt == 8'(MAX_BURST - 1)));
   assign busy      = (state == HOLD) || tx_valid;

   always_ff @(posedge uart_samplig_clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples
      // pre-edge values regardless of statement order.
      if (reset) state <= ARB;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      req_ready  = '0;
      case (state)
         ARB:  if (any_valid) next_state = HOLD;
         HOLD: begin
            req_ready[grant_id] = slot_free;
            if (pkt_end) next_state = ARB;
         end
         default: next_state = ARB;
      endcase
   end

   // Loading a new byte takes priority over clearing tx_valid on a drain.
   always_ff @(posedge uart_samplig_clk) begin
      if (reset) begin
         tx_valid  <= 1'b0;
         tx_data   <= '0;
         grant_id  <= '0;
         burst_cnt <= '0;
         rr_ptr    <= IDX_W'(NUM_REQ - 1);
      end else begin
         if (state == ARB && any_valid) begin
            grant_id  <= winner;
            burst_cnt <= '0;
         end
         if (accept) begin
            tx_data   <= req_data[BYTE_W*grant_id +: BYTE_W];
            tx_valid  <= 1'b1;
            burst_cnt <= burst_cnt + 8'd1;
            if (pkt_end) rr_ptr <= grant_id;
         end else if (tx_ready) begin
            tx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: cycle vectors, directed corner sequences and
// randomized packet traffic checked against a transaction-level byte-order model.
module tb_uart_tx_arbiter;

   localparam int NUM_REQ   = 4;
   localparam int MAX_BURST = 16;

   logic                 uart_samplig_clk;
   logic                 reset;
   logic [NUM_REQ-1:0]   req_valid;
   logic [NUM_REQ-1:0]   req_last;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_ready;
   logic                 tx_valid;
   logic                 tx_ready;
   logic [7:0]           tx_data;
   logic [1:0]           grant_id;
   logic                 busy;

   int n_checks = 0;
   int n_pass   = 0;

   // Per-requester pending bytes, {last, data}; expected and observed transmitter streams.
   logic [8:0] src [NUM_REQ][$];
   logic [7:0] exp_q [$];
   logic [7:0] obs_q [$];

   typedef struct {
      logic [3:0] rv;
      logic [3:0] last;
      logic       txr;
      logic [3:0] e_rdy;
      logic       e_tv;
      logic [7:0] e_data;
      logic [1:0] e_gid;
      logic       e_busy;
   } vec_t;

   vec_t vecs [13];

   uart_tx_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .MAX_BURST (MAX_BURST)
   ) dut (
      .uart_samplig_clk (uart_samplig_clk),
      .reset            (reset),
      .req_valid        (req_valid),
      .req_last         (req_last),
      .req_data         (req_data),
      .req_ready        (req_ready),
      .tx_valid         (tx_valid),
      .tx_ready         (tx_ready),
      .tx_data          (tx_data),
      .grant_id         (grant_id),
      .busy             (busy)
   );

   initial uart_samplig_clk = 1'b0;
   always #5 uart_samplig_clk = ~uart_samplig_clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic reset_dut();
      @(negedge uart_samplig_clk);
      reset     = 1'b1;
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      tx_ready  = 1'b0;
      repeat (2) @(negedge uart_samplig_clk);
      reset = 1'b0;
   endtask

   function automatic bit any_pending();
      for (int i = 0; i < NUM_REQ; i++) if (src[i].size() > 0) return 1'b1;
      return 1'b0;
   endfunction

   // Byte order implied by the arbitration rules, computed on whole queues.
   task automatic build_expected();
      logic [8:0] m [NUM_REQ][$];
      logic [8:0] e;
      int rr, g, cnt;
      bit done;
      for (int i = 0; i < NUM_REQ; i++) m[i] = src[i];
      exp_q.delete();
      rr = NUM_REQ - 1;
      while (1) begin
         g = -1;
         for (int off = 1; off <= NUM_REQ; off++)
            if (g < 0 && m[(rr + off) % NUM_REQ].size() > 0) g = (rr + off) % NUM_REQ;
         if (g < 0) break;
         cnt  = 0;
         done = 1'b0;
         while (!done && m[g].size() > 0) begin
            e = m[g].pop_front();
            exp_q.push_back(e[7:0]);
            cnt++;
            if (e[8] || cnt == MAX_BURST) begin
               rr   = g;
               done = 1'b1;
            end
         end
         if (!done) break;
      end
   endtask

   // Producers present their queue heads; sink takes bytes with always-on or random ready.
   task automatic run_stream(input string tag, input bit rnd);
      int         cyc  = 0;
      int         bad  = 0;
      bit         stall = 1'b0;
      logic [7:0] held = '0;
      int         n;
      reset_dut();
      obs_q.delete();
      while ((any_pending() || tx_valid) && cyc < 3000) begin
         @(negedge uart_samplig_clk);
         for (int i = 0; i < NUM_REQ; i++) begin
            if (src[i].size() > 0) begin
               req_valid[i]      = 1'b1;
               req_last[i]       = src[i][0][8];
               req_data[8*i +: 8] = src[i][0][7:0];
            end else begin
               req_valid[i] = 1'b0;
               req_last[i]  = 1'b0;
            end
         end
         tx_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         #1;
         if (stall && !(tx_valid && tx_data == held)) bad++;
         if (!$onehot0(req_ready)) bad++;
         stall = tx_valid && !tx_ready;
         held  = tx_data;
         if (tx_valid && tx_ready) obs_q.push_back(tx_data);
         for (int i = 0; i < NUM_REQ; i++)
            if (req_valid[i] && req_ready[i]) void'(src[i].pop_front());
         cyc++;
      end
      check({tag, "_timeout"}, 32'(cyc < 3000), 32'd1);
      check({tag, "_protocol_errs"}, 32'(bad), 32'd0);
      check({tag, "_byte_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int k = 0; k < n; k++)
         check($sformatf("%s_byte%0d", tag, k), 32'(obs_q[k]), 32'(exp_q[k]));
   endtask

   initial begin
      int          bad;
      logic [1:0]  grants [$];
      int          npk, len;

      reset_dut();

      // Cycle vectors: req0 and req2 two-byte packets, then a backpressured req1 byte.
      vecs[0]  = '{4'b0101, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0};
      vecs[1]  = '{4'b0101, 4'b0000, 1'b1, 4'b0001, 1'b0, 8'h00, 2'd0, 1'b1};
      vecs[2]  = '{4'b0101, 4'b0001, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0, 1'b1};
      vecs[3]  = '{4'b0100, 4'b0000, 1'b1, 4'b0000, 1'b1, 8'h11, 2'd0, 1'b1};
      vecs[4]  = '{4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b0, 8'h11, 2'd2, 1'b1};
      vecs[5]  = '{4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'h33, 2'd2, 1'b1};
      vecs[6]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 8'h33, 2'd2, 1'b1};
      vecs[7]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h33, 2'd2, 1'b0};
      vecs[8]  = '{4'b0010, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h33, 2'd2, 1'b0};
      vecs[9]  = '{4'b0010, 4'b0010, 1'b0, 4'b0010, 1'b0, 8'h33, 2'd1, 1'b1};
      vecs[10] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 8'h22, 2'd1, 1'b1};
      vecs[11] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 8'h22, 2'd1, 1'b1};
      vecs[12] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h22, 2'd1, 1'b0};

      req_data = {8'h44, 8'h33, 8'h22, 8'h11};
      for (int k = 0; k < 13; k++) begin
         @(negedge uart_samplig_clk);
         req_valid = vecs[k].rv;
         req_last  = vecs[k].last;
         tx_ready  = vecs[k].txr;
         #1;
         check($sformatf("vec%0d_req_ready", k), 32'(req_ready), 32'(vecs[k].e_rdy));
         check($sformatf("vec%0d_tx_valid", k), 32'(tx_valid), 32'(vecs[k].e_tv));
         check($sformatf("vec%0d_tx_data", k), 32'(tx_data), 32'(vecs[k].e_data));
         check($sformatf("vec%0d_grant_id", k), 32'(grant_id), 32'(vecs[k].e_gid));
         check($sformatf("vec%0d_busy", k), 32'(busy), 32'(vecs[k].e_busy));
      end

      // Buffer full with transmitter stalled for 40 cycles; pointer now sits at 1.
      @(negedge uart_samplig_clk);
      req_valid = 4'b0100;
      req_last  = 4'b0000;
      tx_ready  = 1'b0;
      req_data[23:16] = 8'h5A;
      repeat (2) @(negedge uart_samplig_clk);
      bad = 0;
      for (int c = 0; c < 40; c++) begin
         #1;
         if (!(tx_valid === 1'b1 && tx_data === 8'h5A && req_ready === 4'b0000 && busy === 1'b1))
            bad++;
         @(negedge uart_samplig_clk);
      end
      check("stall40_bad_cycles", 32'(bad), 32'd0);

      // Reset in HOLD with a byte buffered drops it and restores requester-0 priority.
      reset = 1'b1;
      @(negedge uart_samplig_clk);
      #1;
      check("rst_hold_tx_valid", 32'(tx_valid), 32'd0);
      check("rst_hold_req_ready", 32'(req_ready), 32'd0);
      check("rst_hold_busy", 32'(busy), 32'd0);
      reset     = 1'b0;
      req_valid = 4'b1111;
      req_last  = 4'b1111;
      tx_ready  = 1'b1;
      for (int c = 0; c < 40 && grants.size() < 5; c++) begin
         #1;
         if (req_ready != 4'b0000) grants.push_back(grant_id);
         @(negedge uart_samplig_clk);
      end
      check("rr_grant_count", 32'(grants.size()), 32'd5);
      for (int k = 0; k < 5 && k < grants.size(); k++)
         check($sformatf("rr_grant%0d", k), 32'(grants[k]), 32'(k % NUM_REQ));

      // Single three-byte packet from requester 0.
      for (int i = 0; i < NUM_REQ; i++) src[i].delete();
      src[0] = '{9'h041, 9'h042, 9'h143};
      exp_q  = '{8'h41, 8'h42, 8'h43};
      run_stream("single_req0", 1'b0);
      check("single_req0_grant_id", 32'(grant_id), 32'd0);
      check("single_req0_busy", 32'(busy), 32'd0);

      // req1 streams 20 unterminated bytes against a waiting 2-byte req3 packet.
      for (int i = 0; i < NUM_REQ; i++) src[i].delete();
      exp_q.delete();
      for (int k = 0; k < 20; k++) src[1].push_back(9'(8'h10 + k));
      src[3] = '{9'h0A0, 9'h1A1};
      for (int k = 0; k < 16; k++) exp_q.push_back(8'(8'h10 + k));
      exp_q.push_back(8'hA0);
      exp_q.push_back(8'hA1);
      for (int k = 16; k < 20; k++) exp_q.push_back(8'(8'h10 + k));
      run_stream("max_burst", 1'b0);

      // Random packet mixes with random transmitter backpressure.
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            src[i].delete();
            npk = $urandom_range(0, 3);
            for (int p = 0; p < npk; p++) begin
               len = $urandom_range(1, 20);
               for (int b = 0; b < len; b++)
                  src[i].push_back({(b == len - 1), 8'($urandom)});
            end
         end
         build_expected();
         run_stream($sformatf("rand%0d", r), 1'b1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
